banked_mem_responder: RTL and testbench

Word-interleaved four-bank memory that responds to the cache controller's block fill/writeback traffic. It accepts one 16-bit read or write per cycle, stalls requests that hit a busy bank, and returns read data on a fixed two-cycle pipeline. It is the memory side of the controller↔memory interface and the standalone memory model for the cache testbenches.

---
 rtl/banked_mem_responder.sv | 103 ++++++++++
 tb/tb_banked_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank word-interleaved memory, 2-cycle read pipe.
// Optional macro BANKED_MEM_ERRCHK_EN enables illegal-request detection on err.
module banked_mem_responder #(
    parameter int BUSY_CYC = 3,
    parameter int MEM_AW   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int RW   = MEM_AW - 3;
    localparam int ROWS = 1 << RW;

    logic [15:0]   r_mem [4][ROWS];
    logic [2:0]    r_cnt [4];
    logic          r_v0;
    logic          r_v1;
    logic [15:0]   r_d0;
    logic [15:0]   r_d1;

    logic [1:0]    w_bank;
    logic [RW-1:0] w_row;
    logic          w_legal;
    logic          w_is_wr;
    logic          w_acc;
    logic          w_unused_addr;

    assign w_bank        = addr[2:1];
    assign w_row         = addr[MEM_AW-1:3];
    assign w_is_wr       = wr;
    assign w_unused_addr = ^addr;

`ifdef BANKED_MEM_ERRCHK_EN
    // Legal only with exactly one of rd/wr and a word-aligned address
    assign w_legal = (rd ^ wr) & ~addr[0];
    assign err     = (rd | wr) & ~w_legal;
`else
    // Any request is taken; rd & wr together acts as a write
    assign w_legal = rd | wr;
    assign err     = 1'b0;
`endif

    assign stall = w_legal & busy[w_bank];
    assign w_acc = w_legal & ~busy[w_bank];

    // Busy flags derive from the per-bank down-counters
    always_comb begin
        busy = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            busy[i] = (r_cnt[i] != 3'd0);
        end
    end

    // Per-bank busy counters: load on accept, count down to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc && (w_bank == 2'(i))) begin
                    r_cnt[i] <= 3'(BUSY_CYC);
                end else if (r_cnt[i] != 3'd0) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_acc && w_is_wr) begin
            r_mem[w_bank][w_row] <= data_in;
        end
    end

    // Two-stage read pipe; the word is captured at the accept edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= 16'h0000;
            r_d1 <= 16'h0000;
        end else begin
            r_v0 <= w_acc & ~w_is_wr;
            r_d0 <= r_mem[w_bank][w_row];
            r_v1 <= r_v0;
            r_d1 <= r_d0;
        end
    end

    assign data_out = r_v1 ? r_d1 : 16'h0000;

endmodule

// File: tb/tb_banked_mem_responder.sv
// tb_banked_mem_responder: directed plus random traffic against a
// cycle-indexed reference model of the banked memory.
module tb_banked_mem_responder;

    localparam int BUSY_CYC = 3;
    localparam int MEM_AW   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    banked_mem_responder #(
        .BUSY_CYC(BUSY_CYC),
        .MEM_AW  (MEM_AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .rd      (rd),
        .wr      (wr),
        .data_out(data_out),
        .stall   (stall),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [15:0] mem_m [int];
    logic [15:0] exp_d [int];
    int          bank_free [4];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h",
                    tag, cyc, obs, exp);
    endtask

    function automatic bit legal_f(input logic r, input logic w,
                                   input logic [15:0] a);
`ifdef BANKED_MEM_ERRCHK_EN
        return (r ^ w) && !a[0];
`else
        return r || w;
`endif
    endfunction

    function automatic int word_f(input logic [15:0] a);
        return (int'(a) >> 1) & ((1 << (MEM_AW - 1)) - 1);
    endfunction

    task automatic step(input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        output bit acc);
        bit         lg;
        int         b;
        int         wd;
        logic [3:0] eb;
        logic [15:0] ed;
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        lg = legal_f(r, w, a);
        b  = int'(a[2:1]);
        for (int n = 0; n < 4; n++) eb[n] = (cyc < bank_free[n]);
        acc = lg && !eb[b];
        ed  = exp_d.exists(cyc) ? exp_d[cyc] : 16'h0000;
        @(negedge clk);
        chk("busy", 16'(busy), 16'(eb));
        chk("stall", 16'(stall), 16'(lg && eb[b]));
        chk("err", 16'(err), 16'((r || w) && !lg));
        chk("data_out", data_out, ed);
        if (acc) begin
            wd = word_f(a);
            if (w) mem_m[wd] = d;
            else exp_d[cyc + 2] = mem_m.exists(wd) ? mem_m[wd] : 16'h0000;
            bank_free[b] = cyc + BUSY_CYC + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, acc);
    endtask

    task automatic do_req(input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          output int tries);
        bit acc;
        tries = 0;
        do begin
            step(r, w, a, d, acc);
            tries++;
        end while (!acc && tries < 20 && legal_f(r, w, a));
        if (legal_f(r, w, a)) chk("req_accepted", 16'(acc), 16'h1);
    endtask

    task automatic reset_cycle();
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        data_in = 16'h0;
        rst     = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_data_out", data_out, 16'h0);
        exp_d.delete();
        for (int n = 0; n < 4; n++) bank_free[n] = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        int t;
        int op;
        bit acc;
        logic [15:0] a;
        rst     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        data_in = 16'h0;
        for (int n = 0; n < 4; n++) bank_free[n] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        idle(2);

        for (int i = 0; i < 64; i++)
            do_req(1'b0, 1'b1, 16'(i * 2), 16'($urandom), t);
        idle(4);

        do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, t);
        idle(4);
        step(1'b1, 1'b0, 16'h0010, 16'h0, acc);
        chk("beef_read_accept", 16'(acc), 16'h1);
        idle(4);

        step(1'b1, 1'b0, 16'h0000, 16'h0, acc);
        step(1'b1, 1'b0, 16'h0002, 16'h0, acc);
        step(1'b1, 1'b0, 16'h0004, 16'h0, acc);
        step(1'b1, 1'b0, 16'h0006, 16'h0, acc);
        idle(4);

        step(1'b1, 1'b0, 16'h0008, 16'h0, acc);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, t);
        chk("bank0_stall_tries", 16'(t), 16'(BUSY_CYC + 1));
        idle(4);

        step(1'b1, 1'b1, 16'h0020, 16'hA5A5, acc);
        step(1'b1, 1'b0, 16'h0021, 16'h0, acc);
        idle(4);

        step(1'b1, 1'b0, 16'h0030, 16'h0, acc);
        reset_cycle();
        idle(4);
        step(1'b1, 1'b0, 16'h0030, 16'h0, acc);
        idle(4);

        do_req(1'b0, 1'b1, 16'h0040, 16'h1234, t);
        do_req(1'b1, 1'b0, 16'h0040, 16'h0, t);
        idle(4);
        step(1'b1, 1'b0, 16'h0040, 16'h0, acc);
        do_req(1'b0, 1'b1, 16'h0040, 16'h5678, t);
        idle(4);
        step(1'b1, 1'b0, 16'h0040, 16'h0, acc);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            a  = 16'($urandom_range(0, 63) * 2);
            if (op <= 3)      step(1'b1, 1'b0, a, 16'h0, acc);
            else if (op <= 6) step(1'b0, 1'b1, a, 16'($urandom), acc);
            else if (op == 7) step(1'b0, 1'b0, a, 16'h0, acc);
            else if (op == 8) step(1'b1, 1'b1, a, 16'($urandom), acc);
            else              step(1'b1, 1'b0, a | 16'h1, 16'h0, acc);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
